// File: rtl/ahb_lite_traffic_gen.sv
// ahb_lite_traffic_gen
// Synthesizable AHB-Lite master. It writes NUM_WORDS generated words (SEED + i) to
// BASE_ADDR + i*ADDR_STEP, reads them back, and counts bus errors and, optionally,
// read-data mismatches.
// Optional feature macro: AHB_TGEN_CHECK_EN builds the read-data comparator. Without it,
// err_count counts only ERROR responses. Bus sequencing is the same in both builds.
module ahb_lite_traffic_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    ADDR_STEP  = 4,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [15:0]           err_count,
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [15:0]           LAST_IDX = 16'(NUM_WORDS - 1);

    logic [1:0]  state;
    logic [15:0] idx;
    logic        dp_valid;
    logic        dp_write;
    logic [15:0] dp_idx;
    logic        err_wait;
    logic        err_hit;
    logic        mismatch;
    logic [15:0] count_next;

    assign HSEL   = busy;
    assign HBURST = 3'b000;
    assign HSIZE  = 3'($clog2(DATA_WIDTH / 8));

    // The first cycle of a two-cycle ERROR response is counted exactly once
    assign err_hit = busy && HRESP && !HREADY && !err_wait;

`ifdef AHB_TGEN_CHECK_EN
    // Compare returned read data with the generated pattern as each read data phase completes
    always_comb begin
        mismatch = 1'b0;
        if (HREADY && !HRESP && dp_valid && !dp_write)
            mismatch = (HRDATA != SEED + DATA_WIDTH'(dp_idx));
    end
`else
    // No comparator: read data and the data-phase tracker only matter to the checker
    logic unused_check;
    assign unused_check = ^{HRDATA, dp_valid, dp_write, dp_idx};
    assign mismatch = 1'b0;
`endif

    // Saturating error counter update for this cycle
    always_comb begin
        count_next = err_count;
        if ((mismatch || err_hit) && err_count != 16'hFFFF)
            count_next = err_count + 16'd1;
    end

    // Pass sequencer: address phases, pipelined write data, error handling and completion
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_idx    <= '0;
            err_wait  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
            HADDR     <= '0;
            HTRANS    <= TRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
        end else begin
            done      <= 1'b0;
            err_count <= count_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_WRITE;
                        busy      <= 1'b1;
                        fail      <= 1'b0;
                        err_count <= '0;
                        err_wait  <= 1'b0;
                        dp_valid  <= 1'b0;
                        idx       <= '0;
                        HADDR     <= BASE_ADDR;
                        HTRANS    <= TRANS_NONSEQ;
                        HWRITE    <= 1'b1;
                    end
                end
                default: begin
                    if (HRESP && HREADY) begin
                        // Second ERROR cycle: abandon the pass
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fail     <= 1'b1;
                        dp_valid <= 1'b0;
                        err_wait <= 1'b0;
                        HTRANS   <= TRANS_IDLE;
                        HWRITE   <= 1'b0;
                    end else if (HRESP) begin
                        // First ERROR cycle: cancel the pending address phase
                        err_wait <= 1'b1;
                        HTRANS   <= TRANS_IDLE;
                    end else if (HREADY) begin
                        dp_valid <= (HTRANS == TRANS_NONSEQ);
                        dp_write <= HWRITE;
                        dp_idx   <= idx;
                        if (HTRANS == TRANS_NONSEQ && HWRITE)
                            HWDATA <= SEED + DATA_WIDTH'(idx);
                        case (state)
                            ST_WRITE: begin
                                if (idx == LAST_IDX) begin
                                    state  <= ST_READ;
                                    idx    <= '0;
                                    HADDR  <= BASE_ADDR;
                                    HWRITE <= 1'b0;
                                end else begin
                                    idx   <= idx + 16'd1;
                                    HADDR <= HADDR + STEP;
                                end
                            end
                            ST_READ: begin
                                if (idx == LAST_IDX) begin
                                    state  <= ST_DRAIN;
                                    HTRANS <= TRANS_IDLE;
                                end else begin
                                    idx   <= idx + 16'd1;
                                    HADDR <= HADDR + STEP;
                                end
                            end
                            ST_DRAIN: begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                fail     <= (count_next != 16'd0);
                                dp_valid <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_traffic_gen.sv
// tb_ahb_lite_traffic_gen
// Directed passes against a memory-like AHB-Lite slave with configurable or random wait
// states, read-data corruption and ERROR injection. Expected transfers, timing and error
// counts come from a pass-level model of the write-then-read sequence.
module tb_ahb_lite_traffic_gen;

    localparam int          NW   = 4;
    localparam logic [31:0] SEED = 32'h100;
    localparam logic [31:0] BASE = 32'h0;
    localparam int          STEP = 4;
`ifdef AHB_TGEN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic        busy, done, fail;
    logic [15:0] err_count;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_lite_traffic_gen #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(NW),
        .BASE_ADDR(BASE), .ADDR_STEP(STEP), .SEED(SEED)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .busy(busy), .done(done),
        .fail(fail), .err_count(err_count), .HSEL(HSEL), .HADDR(HADDR),
        .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    waitsCfg = 0;
    int    corruptIdx = -1;
    int    errIdx = -1;
    int    waitSum = 0;
    int    stableViol = 0;
    int    readAddrSeen = 0;
    bit    errIdleSeen = 0;
    xfer_t xferLog[$];

    logic [31:0] mem [0:NW-1];
    bit          slaveRst = 1'b1;
    bit          dpActive = 0, dpWrite = 0;
    logic [31:0] dpAddr = '0;
    int          waitLeft = 0;
    int          errStage = 0;
    bit          lastReady = 1, lastResp = 0;
    bit          prevNonseq = 0, prevWrite = 0;
    logic [31:0] prevAddr = '0, prevHwdata = '0;
    logic [1:0]  prevTrans = '0;

    bit busyAt1, busyAtDone;
    logic [1:0] transAt1;
    bit rstBusy, rstHsel, rstDone;
    logic [1:0] rstTrans;

    always @(posedge HCLK) begin
        cyc++;
        slaveRst = HRESET;
    end

    // Slave model: evaluated mid-cycle on the bus values of the current cycle
    always @(negedge HCLK) begin
        int idx;
        logic [31:0] rd;
        if (slaveRst) begin
            dpActive = 0; lastReady = 1; lastResp = 0; prevNonseq = 0; errStage = 0;
            HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            if (!lastReady && !lastResp &&
                (HADDR !== prevAddr || HTRANS !== prevTrans || HWRITE !== prevWrite || HWDATA !== prevHwdata))
                stableViol++;
            if (lastReady) begin
                dpActive = prevNonseq; dpWrite = prevWrite; dpAddr = prevAddr;
                waitLeft = (waitsCfg < 0) ? int'($urandom_range(0, 2)) : waitsCfg;
                if (dpActive) waitSum += waitLeft;
                errStage = 0;
            end
            HREADY = 1'b1; HRESP = 1'b0;
            if (dpActive) begin
                idx = int'((dpAddr - BASE) / STEP);
                if (dpWrite && idx == errIdx) begin
                    HRESP = 1'b1;
                    if (errStage == 0) begin
                        HREADY = 1'b0; errStage = 1;
                    end else if (HTRANS == 2'b00) begin
                        errIdleSeen = 1;
                    end
                end else if (waitLeft > 0) begin
                    HREADY = 1'b0; waitLeft--;
                end else if (dpWrite) begin
                    mem[idx] = HWDATA;
                    xferLog.push_back('{w: 1'b1, a: dpAddr, d: HWDATA});
                end else begin
                    rd = (idx == corruptIdx) ? 32'hDEAD : mem[idx];
                    HRDATA = rd;
                    xferLog.push_back('{w: 1'b0, a: dpAddr, d: rd});
                end
            end
            if (HSEL && HTRANS == 2'b10 && !HWRITE) readAddrSeen++;
            prevNonseq = HSEL && HTRANS == 2'b10;
            prevWrite = HWRITE; prevAddr = HADDR; prevTrans = HTRANS; prevHwdata = HWDATA;
            lastReady = HREADY; lastResp = HRESP;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One pass: start sampled in cycle 0; optional extra start and mid-pass reset
    task automatic applyStimulus(input int midStart, input int rstAt,
                                 output int doneCycle, output int pulses);
        doneCycle = -1; pulses = 0;
        xferLog.delete(); waitSum = 0; stableViol = 0; readAddrSeen = 0; errIdleSeen = 0;
        @(negedge HCLK);
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge HCLK);
            start = (k == midStart);
            if (k == 1) begin busyAt1 = busy; transAt1 = HTRANS; end
            if (k == rstAt) HRESET = 1'b1;
            if (rstAt > 0 && k == rstAt + 1) begin
                HRESET = 1'b0;
                rstBusy = busy; rstHsel = HSEL; rstDone = done; rstTrans = HTRANS;
                break;
            end
            if (done) begin
                pulses++;
                if (doneCycle < 0) begin doneCycle = k; busyAtDone = busy; end
            end
            if (doneCycle >= 0 && k >= doneCycle + 4) break;
        end
        start = 1'b0;
    endtask

    // Compare a completed pass with the expected write-then-read sequence
    task automatic checkPass(input string name, input int corrupt, input int expDone,
                             input int doneCycle, input int pulses);
        int          nBad;
        int          w;
        logic [31:0] a, d;
        checkOutput({name, "_done_cycle"}, doneCycle, expDone);
        checkOutput({name, "_done_pulses"}, pulses, 1);
        checkOutput({name, "_busy_cycle1"}, int'(busyAt1), 1);
        checkOutput({name, "_htrans_cycle1"}, int'(transAt1), 2);
        checkOutput({name, "_busy_at_done"}, int'(busyAtDone), 0);
        checkOutput({name, "_xfer_count"}, xferLog.size(), 2 * NW);
        for (int i = 0; i < 2 * NW && i < xferLog.size(); i++) begin
            w = (i < NW) ? 1 : 0;
            a = BASE + 32'((i % NW) * STEP);
            d = SEED + 32'(i % NW);
            if (i >= NW && (i % NW) == corrupt) d = 32'hDEAD;
            checkOutput($sformatf("%s_xfer%0d_dir", name, i), int'(xferLog[i].w), w);
            checkOutput($sformatf("%s_xfer%0d_addr", name, i), int'(xferLog[i].a), int'(a));
            checkOutput($sformatf("%s_xfer%0d_data", name, i), int'(xferLog[i].d), int'(d));
        end
        nBad = (CHECK_EN && corrupt >= 0) ? 1 : 0;
        checkOutput({name, "_err_count"}, int'(err_count), nBad);
        checkOutput({name, "_fail"}, int'(fail), nBad);
        checkOutput({name, "_stable_in_waits"}, stableViol, 0);
    endtask

    initial begin
        int dc, p;
        HRESET = 1'b1; start = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) @(negedge HCLK);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_fail", int'(fail), 0);
        checkOutput("rst_err_count", int'(err_count), 0);
        checkOutput("rst_hsel", int'(HSEL), 0);
        checkOutput("rst_haddr", int'(HADDR), 0);
        checkOutput("rst_htrans", int'(HTRANS), 0);
        checkOutput("rst_hwrite", int'(HWRITE), 0);
        checkOutput("rst_hwdata", int'(HWDATA), 0);
        checkOutput("hburst", int'(HBURST), 0);
        checkOutput("hsize", int'(HSIZE), 2);
        HRESET = 1'b0;
        repeat (2) @(negedge HCLK);

        $display("[TB] zero-wait pass");
        waitsCfg = 0; corruptIdx = -1;
        applyStimulus(0, 0, dc, p);
        checkPass("zero", -1, 2 * NW + 2, dc, p);

        $display("[TB] two wait states per transfer");
        waitsCfg = 2;
        applyStimulus(0, 0, dc, p);
        checkPass("wait2", -1, 2 * NW + 2 + 2 * (2 * NW), dc, p);

        $display("[TB] random waits, random corrupted read");
        waitsCfg = -1; corruptIdx = int'($urandom_range(0, NW - 1));
        applyStimulus(0, 0, dc, p);
        checkPass("rand", corruptIdx, 2 * NW + 2 + waitSum, dc, p);

        $display("[TB] corrupted read of word 2");
        waitsCfg = 0; corruptIdx = 2;
        applyStimulus(0, 0, dc, p);
        checkPass("corrupt2", 2, 2 * NW + 2, dc, p);
        corruptIdx = -1;

        $display("[TB] ERROR response on write 1");
        errIdx = 1;
        applyStimulus(0, 0, dc, p);
        checkOutput("err_done_cycle", dc, errIdx + 4);
        checkOutput("err_done_pulses", p, 1);
        checkOutput("err_htrans_idle", int'(errIdleSeen), 1);
        checkOutput("err_err_count", int'(err_count), 1);
        checkOutput("err_fail", int'(fail), 1);
        checkOutput("err_no_reads", readAddrSeen, 0);
        checkOutput("err_xfer_count", xferLog.size(), errIdx);
        errIdx = -1;

        $display("[TB] start repeated mid-pass");
        applyStimulus(4, 0, dc, p);
        checkPass("midstart", -1, 2 * NW + 2, dc, p);

        $display("[TB] reset during READ");
        applyStimulus(0, NW + 2, dc, p);
        checkOutput("midrst_busy", int'(rstBusy), 0);
        checkOutput("midrst_hsel", int'(rstHsel), 0);
        checkOutput("midrst_done", int'(rstDone), 0);
        checkOutput("midrst_htrans", int'(rstTrans), 0);
        repeat (2) @(negedge HCLK);
        applyStimulus(0, 0, dc, p);
        checkPass("after_rst", -1, 2 * NW + 2, dc, p);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_traffic_gen.md
# ahb_lite_traffic_gen

Synthesizable, parametrised AHB-Lite master that writes a block of NUM_WORDS generated data words to a slave, reads them back and checks them. It is the hardware successor to the simulation-only AHB-Lite master emulator used to exercise ahb_lite_sdram. It connects directly to the slave's AHB-Lite port. Unlike the emulator, it supports configurable width, depth, address stride and data seed, wait states, error responses and self-checking.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; 8, 16 or 32
- NUM_WORDS, 16, transfers per pass; 1..65535
- BASE_ADDR, 0, address of word 0
- ADDR_STEP, 4, byte increment between words; equals DATA_WIDTH/8 or a multiple of it
- SEED, 1, data of word 0
- HCLK  in  1  clock
- HRESET  in  1  reset; one clock, synchronous, active-high
- start  in  1  one-cycle request to run one pass; sampled only in IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of pass
- fail  out  1  sticky until next start; high if err_count != 0 at done
- err_count  out  16  saturating error count for the pass
- HSEL  out  1  high while busy
- HADDR  out  ADDR_WIDTH  address
- HBURST  out  3  constant 3'b000 (SINGLE)
- HSIZE  out  3  log2(DATA_WIDTH/8)
- HTRANS  out  2  IDLE 2'b00 / NONSEQ 2'b10
- HWRITE  out  1  write flag
- HWDATA  out  DATA_WIDTH  write data
- HRDATA  in  DATA_WIDTH  read data
- HREADY  in  1  transfer ready
- HRESP  in  1  0 OKAY, 1 ERROR

## Operation
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> IDLE.
- IDLE, start=1: clear err_count and fail, assert busy, go to WRITE.
- Word i: address is BASE_ADDR + i*ADDR_STEP, truncated to ADDR_WIDTH. Data is SEED + i, modulo 2^DATA_WIDTH.
- WRITE: issue NUM_WORDS NONSEQ write address phases, i = 0..N-1. Index advances only on a cycle with HREADY=1.
- READ: issue NUM_WORDS NONSEQ read address phases. The first read address phase overlaps the data phase of the last write; no idle cycle between them.
- DRAIN: HTRANS=IDLE until the last read data phase completes. Then pulse done, drop busy and HSEL, return to IDLE.
- Pipelining: HWDATA for write i is driven in the cycle after its address phase is accepted. It is held until HREADY=1.
- Read check: when a read data phase completes (HREADY=1, HRESP=0), compare HRDATA with SEED+i. A mismatch increments err_count.
- Error response, first cycle (HRESP=1, HREADY=0):
  - Drive HTRANS=IDLE in the next cycle, cancelling the pending address phase.
  - Increment err_count once.
- Error response, second cycle (HRESP=1, HREADY=1): go to IDLE with a done pulse; fail=1.
- err_count saturates at 16'hFFFF.
- start while busy is ignored.

## Timing
- Reset values: busy 0, done 0, fail 0, err_count 0, HSEL 0, HADDR 0, HTRANS IDLE, HWRITE 0, HWDATA 0.
- HBURST and HSIZE are constants.
- HRESET mid-pass: all outputs return to reset values at the next edge and the FSM goes to IDLE. No bus cleanup is performed.
- Zero-wait slave:
  - First address phase is in cycle 1 after start (start sampled in cycle 0).
  - Address phases occupy cycles 1..2N.
  - Last data phase is in cycle 2N+1.
  - done is high in cycle 2N+2.
- Each HREADY=0 cycle adds exactly one cycle.
- While HREADY=0, HADDR, HTRANS, HWRITE and HWDATA hold, except for the IDLE forced on an error response.
- fail updates in the same cycle as done.

## Configuration
- AHB_TGEN_CHECK_EN defined: read-data compare logic is present, and mismatches count into err_count.
- AHB_TGEN_CHECK_EN undefined: no comparator. err_count counts only HRESP errors, and fail reflects only bus errors.
- Bus sequencing is identical in both builds.

## Test plan
- Zero-wait memory model, NUM_WORDS=4, SEED=32'h100, BASE_ADDR=0 -> writes 0x100..0x103 to 0x0, 0x4, 0x8, 0xC; reads return the same values; done in cycle 10; err_count 0; fail 0.
- Same setup, slave holds HREADY=0 for 2 cycles on every transfer -> address, control and HWDATA stable during waits; done in cycle 26; err_count 0.
- Slave returns 0xDEAD for read of word 2, with AHB_TGEN_CHECK_EN defined -> err_count 1, fail 1. Same stimulus without the macro -> err_count 0, fail 0.
- Slave issues ERROR on write 1 -> HTRANS=IDLE in the cycle after the first error cycle; done in the cycle after the second error cycle; err_count 1; fail 1; no read issued.
- start pulsed again mid-pass -> ignored; exactly one done pulse.
- HRESET asserted during READ -> next cycle busy 0, HTRANS IDLE, HSEL 0. A subsequent start runs a full clean pass.
